// File: rtl/alu_ctrl_seq_if.sv
// EX-stage bundle between the decode/issue side and the ALU control sequencer.
// Signal names match the datapath's existing port names.
interface alu_ctrl_seq_if;
  logic       valid_i;
  logic       flush_i;
  logic [5:0] funct_i;
  logic [2:0] ALUOp_i;
  logic [3:0] ALUCtrl_o;
  logic [1:0] res_sel_o;
  logic       md_start_o;
  logic [1:0] md_op_o;
  logic       md_busy_o;
  logic       hilo_we_o;
  logic       stall_o;
  logic       illegal_o;

  modport master (
    output valid_i, flush_i, funct_i, ALUOp_i,
    input  ALUCtrl_o, res_sel_o, md_start_o, md_op_o, md_busy_o,
           hilo_we_o, stall_o, illegal_o
  );

  modport slave (
    input  valid_i, flush_i, funct_i, ALUOp_i,
    output ALUCtrl_o, res_sel_o, md_start_o, md_op_o, md_busy_o,
           hilo_we_o, stall_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// MIPS EX-stage ALU control: zero-latency funct/ALUOp decode plus a mult/div
// sequencer that pulses start, counts latency, signals HI/LO write and interlocks.
module alu_ctrl_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input logic           clk_i,
  input logic           rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       md_op_q;

  logic [3:0] alu_ctrl;
  logic [1:0] res_sel;
  logic [1:0] md_code;
  logic       is_md;
  logic       is_hilo;
  logic       undef;
  logic       stall;
  logic       md_start;

  always_comb begin
    alu_ctrl = 4'b0000;
    res_sel  = 2'b00;
    md_code  = 2'b00;
    is_md    = 1'b0;
    is_hilo  = 1'b0;
    undef    = 1'b0;
    case (bus.ALUOp_i)
      3'b000: begin
        case (bus.funct_i)
          6'b100001: alu_ctrl = 4'b0010;
          6'b100011: alu_ctrl = 4'b0110;
          6'b100100: alu_ctrl = 4'b0000;
          6'b100101: alu_ctrl = 4'b0001;
          6'b100110: alu_ctrl = 4'b1101;
          6'b100111: alu_ctrl = 4'b1100;
          6'b101010: alu_ctrl = 4'b0111;
          6'b000000: alu_ctrl = 4'b0100;
          6'b000010: alu_ctrl = 4'b1000;
          6'b000011: alu_ctrl = 4'b1110;
          6'b000100: alu_ctrl = 4'b0101;
          6'b000110: alu_ctrl = 4'b1001;
          6'b000111: alu_ctrl = 4'b1111;
          6'b010000: begin res_sel = 2'b01; is_hilo = 1'b1; end
          6'b010010: begin res_sel = 2'b10; is_hilo = 1'b1; end
          // mult/multu/div/divu: low funct bits are the md op code
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            is_md   = 1'b1;
            md_code = bus.funct_i[1:0];
          end
          default: undef = 1'b1;
        endcase
      end
      3'b001:  alu_ctrl = 4'b0010;
      3'b010:  alu_ctrl = 4'b0111;
      3'b011:  alu_ctrl = 4'b0110;
      3'b100:  alu_ctrl = 4'b1010;
      3'b101:  alu_ctrl = 4'b0001;
      3'b110:  alu_ctrl = 4'b0110;
      default: undef = 1'b1;
    endcase
  end

  // Any HI/LO consumer or producer waits while an operation is in flight.
  assign stall    = bus.valid_i & ~bus.flush_i & (is_md | is_hilo) & (state == RUN);
  assign md_start = bus.valid_i & ~bus.flush_i & is_md & ~stall;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      md_op_q <= 2'b00;
    end else if (state == RUN) begin
      if (bus.flush_i || cnt == '0) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (md_start) begin
      state   <= RUN;
      md_op_q <= md_code;
      cnt     <= md_code[1] ? DIV_LOAD : MUL_LOAD;
    end
  end

  assign bus.ALUCtrl_o  = alu_ctrl;
  assign bus.res_sel_o  = res_sel;
  assign bus.illegal_o  = bus.valid_i & undef;
  assign bus.stall_o    = stall;
  assign bus.md_start_o = md_start;
  assign bus.md_op_o    = md_op_q;
  assign bus.md_busy_o  = (state == RUN);
  // A flush in the final RUN cycle suppresses the write-back.
  assign bus.hilo_we_o  = (state == RUN) & (cnt == '0) & ~bus.flush_i;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode sweep, mult/div sequencing, interlock,
// flush, async reset and the single-cycle multiplier corner.
module tb_alu_ctrl_seq;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  alu_ctrl_seq_if ifa ();
  alu_ctrl_seq_if ifb ();

  alu_ctrl_seq #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .bus(ifa.slave)
  );

  alu_ctrl_seq #(.MUL_CYCLES(1), .DIV_CYCLES(2), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic fl, input logic [5:0] fn, input logic [2:0] op);
    ifa.valid_i = v; ifa.flush_i = fl; ifa.funct_i = fn; ifa.ALUOp_i = op;
  endtask

  task automatic drive_b(input logic v, input logic fl, input logic [5:0] fn, input logic [2:0] op);
    ifb.valid_i = v; ifb.flush_i = fl; ifb.funct_i = fn; ifb.ALUOp_i = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 6'b011000, 3'b000);
    drive_b(1'b0, 1'b0, 6'b011000, 3'b000);
    #12;
    vecs++;
    if (ifa.md_busy_o !== 1'b0 || ifa.hilo_we_o !== 1'b0 || ifa.md_op_o !== 2'b00 ||
        ifa.stall_o !== 1'b0 || ifa.md_start_o !== 1'b0) begin
      errs++;
      $display("FAIL reset_a: busy=%b we=%b op=%b stall=%b start=%b, want all 0",
               ifa.md_busy_o, ifa.hilo_we_o, ifa.md_op_o, ifa.stall_o, ifa.md_start_o);
    end
    vecs++;
    if (ifb.md_busy_o !== 1'b0 || ifb.hilo_we_o !== 1'b0 || ifb.md_op_o !== 2'b00) begin
      errs++;
      $display("FAIL reset_b: busy=%b we=%b op=%b, want all 0",
               ifb.md_busy_o, ifb.hilo_we_o, ifb.md_op_o);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_decode();
    logic [5:0] fn_tab [13] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                                6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011,
                                6'b000100, 6'b000110, 6'b000111};
    logic [3:0] fn_exp [13] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1101,
                                4'b1100, 4'b0111, 4'b0100, 4'b1000, 4'b1110,
                                4'b0101, 4'b1001, 4'b1111};
    logic [3:0] op_exp [6]  = '{4'b0010, 4'b0111, 4'b0110, 4'b1010, 4'b0001, 4'b0110};
    for (int i = 0; i < 13; i++) begin
      drive_a(1'b1, 1'b0, fn_tab[i], 3'b000);
      #1;
      vecs++;
      if (ifa.ALUCtrl_o !== fn_exp[i] || ifa.illegal_o !== 1'b0 || ifa.res_sel_o !== 2'b00) begin
        errs++;
        $display("FAIL decode_rtype funct=%b: ctrl=%b ill=%b sel=%b, want ctrl=%b ill=0 sel=00",
                 fn_tab[i], ifa.ALUCtrl_o, ifa.illegal_o, ifa.res_sel_o, fn_exp[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, 1'b0, 6'b111111, 3'(i + 1));
      #1;
      vecs++;
      if (ifa.ALUCtrl_o !== op_exp[i] || ifa.illegal_o !== 1'b0) begin
        errs++;
        $display("FAIL decode_aluop op=%0d: ctrl=%b ill=%b, want ctrl=%b ill=0",
                 i + 1, ifa.ALUCtrl_o, ifa.illegal_o, op_exp[i]);
      end
    end
    drive_a(1'b1, 1'b0, 6'b100001, 3'b111);
    #1;
    vecs++;
    if (ifa.ALUCtrl_o !== 4'b0000 || ifa.illegal_o !== 1'b1 || ifa.res_sel_o !== 2'b00) begin
      errs++;
      $display("FAIL decode_op111: ctrl=%b ill=%b sel=%b, want 0000 1 00",
               ifa.ALUCtrl_o, ifa.illegal_o, ifa.res_sel_o);
    end
    drive_a(1'b1, 1'b0, 6'b111111, 3'b000);
    #1;
    vecs++;
    if (ifa.ALUCtrl_o !== 4'b0000 || ifa.illegal_o !== 1'b1) begin
      errs++;
      $display("FAIL decode_bad_funct: ctrl=%b ill=%b, want 0000 1", ifa.ALUCtrl_o, ifa.illegal_o);
    end
    drive_a(1'b0, 1'b0, 6'b111111, 3'b000);
    #1;
    vecs++;
    if (ifa.illegal_o !== 1'b0) begin
      errs++;
      $display("FAIL decode_bad_novalid: ill=%b, want 0", ifa.illegal_o);
    end
    drive_a(1'b1, 1'b0, 6'b010000, 3'b000);
    #1;
    vecs++;
    if (ifa.res_sel_o !== 2'b01 || ifa.ALUCtrl_o !== 4'b0000 || ifa.stall_o !== 1'b0) begin
      errs++;
      $display("FAIL decode_mfhi: sel=%b ctrl=%b stall=%b, want 01 0000 0",
               ifa.res_sel_o, ifa.ALUCtrl_o, ifa.stall_o);
    end
    drive_a(1'b1, 1'b0, 6'b010010, 3'b000);
    #1;
    vecs++;
    if (ifa.res_sel_o !== 2'b10 || ifa.ALUCtrl_o !== 4'b0000) begin
      errs++;
      $display("FAIL decode_mflo: sel=%b ctrl=%b, want 10 0000", ifa.res_sel_o, ifa.ALUCtrl_o);
    end
    drive_a(1'b0, 1'b0, 6'b000000, 3'b000);
    cyc();
  endtask

  task automatic test_mult();
    drive_a(1'b1, 1'b0, 6'b011000, 3'b000);
    #1;
    vecs++;
    if (ifa.md_start_o !== 1'b1 || ifa.md_busy_o !== 1'b0 || ifa.ALUCtrl_o !== 4'b0000) begin
      errs++;
      $display("FAIL mult_issue: start=%b busy=%b ctrl=%b, want 1 0 0000",
               ifa.md_start_o, ifa.md_busy_o, ifa.ALUCtrl_o);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      drive_a(1'b0, 1'b0, 6'b000000, 3'b000);
      #1;
      vecs++;
      if (ifa.md_busy_o !== (k <= 4) || ifa.hilo_we_o !== (k == 4) || ifa.md_op_o !== 2'b00) begin
        errs++;
        $display("FAIL mult_cycle%0d: busy=%b we=%b op=%b, want busy=%b we=%b op=00",
                 k, ifa.md_busy_o, ifa.hilo_we_o, ifa.md_op_o, k <= 4, k == 4);
      end
    end
  endtask

  task automatic test_divu_mflo();
    drive_a(1'b1, 1'b0, 6'b011011, 3'b000);
    #1;
    vecs++;
    if (ifa.md_start_o !== 1'b1) begin
      errs++;
      $display("FAIL divu_issue: start=%b, want 1", ifa.md_start_o);
    end
    for (int k = 1; k <= 32; k++) begin
      cyc();
      drive_a(1'b1, 1'b0, 6'b010010, 3'b000);
      #1;
      vecs++;
      if (ifa.stall_o !== 1'b1 || ifa.hilo_we_o !== (k == 32) || ifa.md_op_o !== 2'b11 ||
          ifa.md_start_o !== 1'b0) begin
        errs++;
        $display("FAIL divu_run%0d: stall=%b we=%b op=%b start=%b, want 1 %b 11 0",
                 k, ifa.stall_o, ifa.hilo_we_o, ifa.md_op_o, ifa.md_start_o, k == 32);
      end
    end
    cyc();
    #1;
    vecs++;
    if (ifa.stall_o !== 1'b0 || ifa.res_sel_o !== 2'b10 || ifa.md_busy_o !== 1'b0) begin
      errs++;
      $display("FAIL divu_mflo_accept: stall=%b sel=%b busy=%b, want 0 10 0",
               ifa.stall_o, ifa.res_sel_o, ifa.md_busy_o);
    end
    drive_a(1'b0, 1'b0, 6'b000000, 3'b000);
    cyc();
  endtask

  task automatic test_flush();
    logic saw_we;
    saw_we = 1'b0;
    drive_a(1'b1, 1'b0, 6'b011010, 3'b000);
    for (int k = 1; k <= 13; k++) begin
      cyc();
      drive_a(1'b0, 1'b0, 6'b000000, 3'b000);
      if (k == 10) drive_a(1'b1, 1'b0, 6'b100001, 3'b000);
      if (k == 12) drive_a(1'b1, 1'b1, 6'b011000, 3'b000);
      #1;
      if (ifa.hilo_we_o === 1'b1) saw_we = 1'b1;
      if (k == 10) begin
        vecs++;
        if (ifa.stall_o !== 1'b0 || ifa.ALUCtrl_o !== 4'b0010 || ifa.md_busy_o !== 1'b1 ||
            ifa.md_op_o !== 2'b10) begin
          errs++;
          $display("FAIL flush_addu_in_run: stall=%b ctrl=%b busy=%b op=%b, want 0 0010 1 10",
                   ifa.stall_o, ifa.ALUCtrl_o, ifa.md_busy_o, ifa.md_op_o);
        end
      end
      if (k == 12) begin
        vecs++;
        if (ifa.md_start_o !== 1'b0 || ifa.stall_o !== 1'b0 || ifa.hilo_we_o !== 1'b0) begin
          errs++;
          $display("FAIL flush_cycle: start=%b stall=%b we=%b, want 0 0 0",
                   ifa.md_start_o, ifa.stall_o, ifa.hilo_we_o);
        end
      end
      if (k == 13) begin
        vecs++;
        if (ifa.md_busy_o !== 1'b0) begin
          errs++;
          $display("FAIL flush_idle_next: busy=%b, want 0", ifa.md_busy_o);
        end
      end
    end
    for (int k = 0; k < 30; k++) begin
      cyc();
      #1;
      if (ifa.hilo_we_o === 1'b1 || ifa.md_busy_o === 1'b1) saw_we = 1'b1;
    end
    vecs++;
    if (saw_we !== 1'b0) begin
      errs++;
      $display("FAIL flush_no_writeback: saw_we_or_busy=%b, want 0", saw_we);
    end
  endtask

  task automatic test_reset_mid();
    drive_a(1'b1, 1'b0, 6'b011001, 3'b000);
    cyc();
    drive_a(1'b0, 1'b0, 6'b000000, 3'b000);
    #1;
    vecs++;
    if (ifa.md_busy_o !== 1'b1 || ifa.md_op_o !== 2'b01) begin
      errs++;
      $display("FAIL rstmid_running: busy=%b op=%b, want 1 01", ifa.md_busy_o, ifa.md_op_o);
    end
    cyc();
    #1;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (ifa.md_busy_o !== 1'b0 || ifa.hilo_we_o !== 1'b0 || ifa.md_op_o !== 2'b00 ||
        ifa.stall_o !== 1'b0 || ifa.md_start_o !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_async: busy=%b we=%b op=%b stall=%b start=%b, want all 0",
               ifa.md_busy_o, ifa.hilo_we_o, ifa.md_op_o, ifa.stall_o, ifa.md_start_o);
    end
    cyc();
    rst_n = 1'b1;
    vecs++;
    if (ifa.md_busy_o !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_after_release: busy=%b, want 0", ifa.md_busy_o);
    end
    cyc();
    drive_a(1'b1, 1'b0, 6'b011000, 3'b000);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      drive_a(1'b0, 1'b0, 6'b000000, 3'b000);
      #1;
      vecs++;
      if (ifa.md_busy_o !== (k <= 4) || ifa.hilo_we_o !== (k == 4) || ifa.md_op_o !== 2'b00) begin
        errs++;
        $display("FAIL rstmid_new_mult%0d: busy=%b we=%b op=%b, want busy=%b we=%b op=00",
                 k, ifa.md_busy_o, ifa.hilo_we_o, ifa.md_op_o, k <= 4, k == 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive_b(1'b1, 1'b0, 6'b011000, 3'b000);
    #1;
    vecs++;
    if (ifb.md_start_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_first_start: start=%b, want 1", ifb.md_start_o);
    end
    cyc();
    #1;
    vecs++;
    if (ifb.stall_o !== 1'b1 || ifb.hilo_we_o !== 1'b1 || ifb.md_busy_o !== 1'b1 ||
        ifb.md_start_o !== 1'b0) begin
      errs++;
      $display("FAIL b2b_cycle1: stall=%b we=%b busy=%b start=%b, want 1 1 1 0",
               ifb.stall_o, ifb.hilo_we_o, ifb.md_busy_o, ifb.md_start_o);
    end
    cyc();
    #1;
    vecs++;
    if (ifb.stall_o !== 1'b0 || ifb.md_start_o !== 1'b1 || ifb.hilo_we_o !== 1'b0 ||
        ifb.md_busy_o !== 1'b0) begin
      errs++;
      $display("FAIL b2b_cycle2: stall=%b start=%b we=%b busy=%b, want 0 1 0 0",
               ifb.stall_o, ifb.md_start_o, ifb.hilo_we_o, ifb.md_busy_o);
    end
    cyc();
    drive_b(1'b0, 1'b0, 6'b000000, 3'b000);
    #1;
    vecs++;
    if (ifb.md_busy_o !== 1'b1 || ifb.hilo_we_o !== 1'b1) begin
      errs++;
      $display("FAIL b2b_cycle3: busy=%b we=%b, want 1 1", ifb.md_busy_o, ifb.hilo_we_o);
    end
    cyc();
    #1;
    vecs++;
    if (ifb.md_busy_o !== 1'b0 || ifb.hilo_we_o !== 1'b0) begin
      errs++;
      $display("FAIL b2b_cycle4: busy=%b we=%b, want 0 0", ifb.md_busy_o, ifb.hilo_we_o);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_decode();
    test_mult();
    test_divu_mflo();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
